// File: rtl/lane_arbiter_scheduler_if.sv
// Two-lane write side plus the arbitrated valid/ready output path of lane_arbiter_scheduler.
interface lane_arbiter_scheduler_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] data_in_0;
    logic              valid_in_0;
    logic [DATA_W-1:0] data_in_1;
    logic              valid_in_1;
    logic              ready_in;
    logic              full_0;
    logic              full_1;
    logic              drop_0;
    logic              drop_1;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic              lane_out;

    modport master (
        output data_in_0, valid_in_0, data_in_1, valid_in_1, ready_in,
        input  full_0, full_1, drop_0, drop_1, data_out, valid_out, lane_out
    );

    modport slave (
        input  data_in_0, valid_in_0, data_in_1, valid_in_1, ready_in,
        output full_0, full_1, drop_0, drop_1, data_out, valid_out, lane_out
    );
endinterface

// File: rtl/lane_arbiter_scheduler.sv
// Two per-lane FIFOs drained round-robin into one registered valid/ready output stage.
// lane_out tags which lane each delivered word came from.
module lane_arbiter_scheduler #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_W     = 2
) (
    input  logic                      clk8f,
    input  logic                      reset,
    lane_arbiter_scheduler_if.slave   bus
);
    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] mem [2][FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr [2];
    logic [ADDR_W-1:0] rd_ptr [2];
    logic [CNT_W-1:0]  count [2];
    logic [CNT_W-1:0]  count_nxt [2];
    logic [1:0]        full;
    logic [1:0]        drop;
    logic [1:0]        valid_in_c;
    logic [DATA_W-1:0] data_in_c [2];
    logic [1:0]        push_c;
    logic [1:0]        pop_c;
    logic [1:0]        nonempty_c;
    logic              grant_c;
    logic              load_c;
    logic              last_grant;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic              lane_out;

    assign valid_in_c   = {bus.valid_in_1, bus.valid_in_0};
    assign data_in_c[0] = bus.data_in_0;
    assign data_in_c[1] = bus.data_in_1;

    assign bus.full_0    = full[0];
    assign bus.full_1    = full[1];
    assign bus.drop_0    = drop[0];
    assign bus.drop_1    = drop[1];
    assign bus.data_out  = data_out;
    assign bus.valid_out = valid_out;
    assign bus.lane_out  = lane_out;

    // Arbitration, next state and FIFO bookkeeping; full gates pushes using the pre-edge count.
    always_comb begin
        state_nxt  = state;
        grant_c    = 1'b0;
        load_c     = 1'b0;
        push_c     = 2'b00;
        pop_c      = 2'b00;
        nonempty_c = 2'b00;
        for (int i = 0; i < 2; i++) begin
            nonempty_c[i] = (count[i] != '0);
        end

        if (nonempty_c == 2'b11) begin
            grant_c = ~last_grant;
        end else begin
            grant_c = nonempty_c[1];
        end
        load_c = (|nonempty_c) && ((state == IDLE) || bus.ready_in);

        case (state)
            IDLE:    if (load_c) state_nxt = BUSY;
            BUSY:    if (bus.ready_in && !load_c) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        for (int i = 0; i < 2; i++) begin
            push_c[i]    = valid_in_c[i] & ~full[i];
            pop_c[i]     = load_c & (grant_c == 1'(i));
            count_nxt[i] = count[i] + CNT_W'(push_c[i]) - CNT_W'(pop_c[i]);
        end
    end

    // FIFO storage is not reset; only counts and pointers define its contents.
    always_ff @(posedge clk8f) begin
        for (int i = 0; i < 2; i++) begin
            if (push_c[i]) mem[i][wr_ptr[i]] <= data_in_c[i];
        end
    end

    always_ff @(posedge clk8f or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            data_out   <= '0;
            valid_out  <= 1'b0;
            lane_out   <= 1'b0;
            last_grant <= 1'b1;
            full       <= 2'b00;
            drop       <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                count[i]  <= '0;
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            for (int i = 0; i < 2; i++) begin
                count[i] <= count_nxt[i];
                full[i]  <= (count_nxt[i] == CNT_W'(FIFO_DEPTH));
                drop[i]  <= valid_in_c[i] & full[i];
                if (push_c[i]) wr_ptr[i] <= wr_ptr[i] + ADDR_W'(1);
                if (pop_c[i])  rd_ptr[i] <= rd_ptr[i] + ADDR_W'(1);
            end

            if (load_c) begin
                data_out   <= mem[grant_c][rd_ptr[grant_c]];
                lane_out   <= grant_c;
                valid_out  <= 1'b1;
                last_grant <= grant_c;
            end else if ((state == BUSY) && bus.ready_in) begin
                valid_out  <= 1'b0;
            end
        end
    end
endmodule
